// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the core-to-APB bridge.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  // Counter width able to hold values 0..max_count.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/apb_bus.sv
// APB3 bus bundle; the bridge drives it through the Master modport.
interface APB_BUS #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles and flags the cycle on which the wait budget runs out.
// Only instantiated when APB_BRIDGE_TIMEOUT_EN is defined.
module apb_timeout_cnt
  import apb_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  // cnt holds the number of ACCESS cycles already completed; saturates at LAST
  logic [CW-1:0] cnt;

  // ACCESS-cycle counter, cleared while in SETUP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired_c = en && (cnt == LAST);

endmodule

// File: rtl/core2apb_bridge.sv
// Core data-port to APB3 master bridge: one outstanding transfer at a time.
// Optional ACCESS timeout enabled by defining APB_BRIDGE_TIMEOUT_EN.
module core2apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic [APB_ADDR_WIDTH-1:0] data_addr_i,
  input  logic                      data_we_i,
  input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
  output logic                      data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
  output logic                      data_err_o,
  APB_BUS.Master                    apb_master
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                    state;
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic                      timeout;

`ifdef APB_BRIDGE_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .clr      (state == SETUP),
    .en       (state == ACCESS),
    .expired_c(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Grant only from IDLE and never while reset is held
  assign data_gnt_o = data_req_i && !rst_i && (state == IDLE);

  // Transfer FSM with registered APB and response outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      paddr         <= '0;
      pwdata        <= '0;
      pwrite        <= 1'b0;
      psel          <= 1'b0;
      penable       <= 1'b0;
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_req_i) begin
            state  <= SETUP;
            paddr  <= data_addr_i;
            pwdata <= data_wdata_i;
            pwrite <= data_we_i;
            psel   <= 1'b1;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          // pready on the terminal cycle wins over the timeout
          if (apb_master.pready) begin
            state         <= RESP;
            psel          <= 1'b0;
            penable       <= 1'b0;
            data_rvalid_o <= 1'b1;
            data_rdata_o  <= pwrite ? '0 : apb_master.prdata;
            data_err_o    <= apb_master.pslverr;
          end else if (timeout) begin
            state         <= RESP;
            psel          <= 1'b0;
            penable       <= 1'b0;
            data_rvalid_o <= 1'b1;
            data_rdata_o  <= '0;
            data_err_o    <= 1'b1;
          end
        end
        RESP: begin
          state         <= IDLE;
          data_rvalid_o <= 1'b0;
          data_rdata_o  <= '0;
          data_err_o    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign apb_master.paddr   = paddr;
  assign apb_master.pwdata  = pwdata;
  assign apb_master.pwrite  = pwrite;
  assign apb_master.psel    = psel;
  assign apb_master.penable = penable;

endmodule

// File: tb/tb_core2apb_bridge.sv
// Self-checking bench for core2apb_bridge; covers the timeout path when
// APB_BRIDGE_TIMEOUT_EN is defined (instance uses TIMEOUT_CYCLES = 4).
`timescale 1ns/1ps
module tb_core2apb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        data_req_i;
  logic        data_gnt_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

  core2apb_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .data_req_i   (data_req_i),
    .data_gnt_o   (data_gnt_o),
    .data_addr_i  (data_addr_i),
    .data_we_i    (data_we_i),
    .data_wdata_i (data_wdata_i),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .apb_master   (apb)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int rvalid_cyc  = -1;
  int n_rvalid    = 0;

  // Advance one cycle and score whatever the response port shows
  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    #1;
    cyc++;
    vectors++;
    if (data_rvalid_o === 1'b1) begin
      rvalid_cyc = cyc;
      n_rvalid++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rvalid: cycle %0d rdata=%h err=%b with no pending request", cyc, data_rdata_o, data_err_o);
      end else begin
        e = sb.pop_front();
        if ({data_rdata_o, data_err_o} !== {e.rdata, e.err}) begin
          miscompares++;
          $display("FAIL response: got rdata=%h err=%b, expected rdata=%h err=%b", data_rdata_o, data_err_o, e.rdata, e.err);
        end
      end
    end else if ({data_rdata_o, data_err_o} !== 33'h0) begin
      miscompares++;
      $display("FAIL idle_resp_zero: got rdata=%h err=%b, expected 0/0", data_rdata_o, data_err_o);
    end
  endtask

  // Issue one transfer, play the APB slave, check bus phases and latency.
  // Returns with the bridge in RESP.
  task automatic do_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic slverr,
                        input logic timeout_exp, output int g);
    exp_t e;
    g = -1;
    rvalid_cyc = -1;
    data_req_i = 1'b1;
    data_addr_i = addr;
    data_we_i = we;
    data_wdata_i = wdata;
    for (int k = 0; k < 8 && g < 0; k++) begin
      #1;
      if (data_gnt_o === 1'b1) g = cyc;
      else tick();
    end
    vectors++;
    if (g < 0) begin
      miscompares++;
      $display("FAIL grant_wait: got no grant within 8 cycles, expected a grant");
      data_req_i = 1'b0;
      return;
    end
    e.rdata = (we || timeout_exp) ? 32'h0 : rdata;
    e.err   = timeout_exp ? 1'b1 : slverr;
    sb.push_back(e);
    tick();
    data_req_i = 1'b0;
    data_addr_i = $urandom;
    data_wdata_i = $urandom;
    data_we_i = ~we;
    apb.pready = 1'b1;
    vectors++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== {2'b10, we, addr, wdata}) begin
      miscompares++;
      $display("FAIL setup_phase: got sel/en=%b%b we=%b addr=%h wdata=%h, expected 10 %b %h %h",
               apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, we, addr, wdata);
    end
    tick();
    for (int i = 0; i <= waits; i++) begin
      vectors++;
      if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata} !== {2'b11, we, addr, wdata}) begin
        miscompares++;
        $display("FAIL access_phase[%0d]: got sel/en=%b%b we=%b addr=%h wdata=%h, expected 11 %b %h %h",
                 i, apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, we, addr, wdata);
      end
      apb.pready  = (i == waits) && !timeout_exp;
      apb.prdata  = (i == waits) ? rdata : $urandom;
      apb.pslverr = (i == waits) ? slverr : 1'b1;
      tick();
    end
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    vectors++;
    if (rvalid_cyc != g + 3 + waits) begin
      miscompares++;
      $display("FAIL latency: got rvalid at cycle %0d, expected %0d", rvalid_cyc, g + 3 + waits);
    end
    vectors++;
    if ({apb.psel, apb.penable, apb.paddr} !== {2'b00, addr}) begin
      miscompares++;
      $display("FAIL resp_bus: got sel/en=%b%b addr=%h, expected 00 %h", apb.psel, apb.penable, apb.paddr, addr);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    vectors++;
    if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, data_rvalid_o, data_rdata_o, data_err_o, data_gnt_o} !== 102'h0) begin
      miscompares++;
      $display("FAIL reset_state: got sel=%b en=%b we=%b addr=%h wdata=%h rvalid=%b rdata=%h err=%b gnt=%b, expected all 0",
               apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, data_rvalid_o, data_rdata_o, data_err_o, data_gnt_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_read_basic();
    int g;
    do_txn(32'h1A10_1000, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, g);
    tick();
  endtask

  task automatic test_write_wait();
    int g;
    do_txn(32'h1A10_0004, 1'b1, 32'h0000_00FF, 3, 32'h1234_5678, 1'b0, 1'b0, g);
    tick();
  endtask

  task automatic test_back_to_back();
    int g1, g2, resp_c;
    do_txn(32'h1A10_2000, 1'b0, 32'h0, 1, 32'h5555_AAAA, 1'b1, 1'b0, g1);
    resp_c = cyc;
    do_txn(32'h1A10_2004, 1'b0, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, g2);
    vectors++;
    if (g2 != resp_c + 1) begin
      miscompares++;
      $display("FAIL b2b_grant: got second grant at cycle %0d, expected %0d", g2, resp_c + 1);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n0, g, rel_c;
    data_req_i = 1'b1;
    data_addr_i = 32'h1A10_3000;
    data_we_i = 1'b1;
    data_wdata_i = 32'hA5A5_A5A5;
    #1;
    tick();
    data_req_i = 1'b0;
    tick();
    apb.pready = 1'b0;
    n0 = n_rvalid;
    rst_i = 1'b1;
    #1;
    vectors++;
    if ({apb.psel, apb.penable, apb.paddr, apb.pwdata} !== 66'h0) begin
      miscompares++;
      $display("FAIL reset_abort: got sel/en=%b%b addr=%h wdata=%h, expected all 0", apb.psel, apb.penable, apb.paddr, apb.pwdata);
    end
    tick();
    tick();
    rst_i = 1'b0;
    rel_c = cyc;
    do_txn(32'h1A10_3004, 1'b0, 32'h0, 2, 32'h7777_1234, 1'b0, 1'b0, g);
    vectors++;
    if (g < 0 || g > rel_c + 1) begin
      miscompares++;
      $display("FAIL post_reset_grant: got grant at cycle %0d, expected by cycle %0d", g, rel_c + 1);
    end
    vectors++;
    if (n_rvalid != n0 + 1) begin
      miscompares++;
      $display("FAIL aborted_no_resp: got %0d responses, expected %0d", n_rvalid - n0, 1);
    end
    tick();
  endtask

  task automatic test_random();
    int g;
    for (int n = 0; n < 6; n++) begin
      do_txn($urandom, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
             $urandom, 1'($urandom_range(0, 1)), 1'b0, g);
      tick();
    end
  endtask

`ifdef APB_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    int g;
    do_txn(32'h1A10_4000, 1'b0, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 1'b1, g);
    tick();
    do_txn(32'h1A10_4004, 1'b0, 32'h0, 3, 32'hCAFE_F00D, 1'b0, 1'b0, g);
    tick();
  endtask
`endif

  initial begin
    rst_i = 1'b1;
    data_req_i = 1'b0;
    data_addr_i = '0;
    data_we_i = 1'b0;
    data_wdata_i = '0;
    apb.prdata = '0;
    apb.pready = 1'b0;
    apb.pslverr = 1'b0;
    test_reset();
    test_read_basic();
    test_write_wait();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef APB_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d outstanding responses, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
